// File: rtl/regf_wr_arb.sv
// Round-robin arbiter for the three writeback sources that share register file port C.
// Grants are combinational; the selected write is registered one cycle later onto addrc/dc/wec.
module regf_wr_arb #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] addr2,
  input  logic [31:0]      data0,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  output logic [2:0]       ack,
  output logic [WIDTH-1:0] addrc,
  output logic [31:0]      dc,
  output logic             wec,
  output logic             conflict
);

  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] addrc_q, addrc_d;
  logic [31:0]      dc_q, dc_d;
  logic             wec_q, wec_d;
  logic             conflict_q, conflict_d;

  logic [1:0]       first, second, third;
  logic [1:0]       win;
  logic             grant;
  logic [WIDTH-1:0] selAddr;
  logic [31:0]      selData;

  // Scan order starts at ptr and wraps mod 3; reset suppresses any grant.
  always_comb begin
    first  = 2'd0;
    second = 2'd1;
    third  = 2'd2;
    case (ptr_q)
      2'd1:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd2:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase

    grant = !reset && !halt && (req != 3'b000);

    if (req[first])       win = first;
    else if (req[second]) win = second;
    else                  win = third;

    ack = 3'b000;
    if (grant) ack[win] = 1'b1;
  end

  always_comb begin
    case (win)
      2'd1:    begin selAddr = addr1; selData = data1; end
      2'd2:    begin selAddr = addr2; selData = data2; end
      default: begin selAddr = addr0; selData = data0; end
    endcase
  end

  // addrc/dc hold their last written value when nothing is granted.
  always_comb begin
    ptr_d      = ptr_q;
    addrc_d    = addrc_q;
    dc_d       = dc_q;
    wec_d      = 1'b0;
    conflict_d = !halt && ($countones(req) >= 2);
    if (grant) begin
      ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
      addrc_d = selAddr;
      dc_d    = selData;
      wec_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 2'd0;
      addrc_q    <= '0;
      dc_q       <= 32'd0;
      wec_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      addrc_q    <= addrc_d;
      dc_q       <= dc_d;
      wec_q      <= wec_d;
      conflict_q <= conflict_d;
    end
  end

  assign addrc    = addrc_q;
  assign dc       = dc_q;
  assign wec      = wec_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_regf_wr_arb.sv
// Bench for regf_wr_arb: directed vectors with hand-computed grants feed a write queue,
// and an independent monitor matches each registered port-C write against it.
module tb_regf_wr_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [4:0]  addr0 = '0, addr1 = '0, addr2 = '0;
  logic [31:0] data0 = '0, data1 = '0, data2 = '0;
  logic [2:0]  ack;
  logic [4:0]  addrc;
  logic [31:0] dc;
  logic        wec;
  logic        conflict;

  typedef struct {
    int          due;
    logic [4:0]  a;
    logic [31:0] d;
  } wrT;

  wrT          wrQ[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        confNext = 1'b0;
  logic        confExp = 1'b0;
  logic        armed = 1'b0;
  logic [4:0]  holdAddr = '0;
  logic [31:0] holdData = '0;
  logic [31:0] rfModel [32];

  regf_wr_arb #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .halt(halt), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .addrc(addrc), .dc(dc), .wec(wec), .conflict(conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational grant and queues the expected write.
  task automatic applyStimulus(input logic rst, input logic hlt, input logic [2:0] r,
                               input logic [2:0] expAck,
                               input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    wrT e;
    @(posedge clk);
    #1;
    reset = rst; halt = hlt; req = r;
    addr0 = a0; addr1 = a1; addr2 = a2;
    data0 = d0; data1 = d1; data2 = d2;
    @(negedge clk);
    checkOutput("ack", {29'd0, ack}, {29'd0, expAck});
    confNext = !rst && !hlt && ($countones(r) >= 2);
    if (expAck != 3'b000) begin
      e.due = cyc + 1;
      case (expAck)
        3'b010:  begin e.a = a1; e.d = d1; end
        3'b100:  begin e.a = a2; e.d = d2; end
        default: begin e.a = a0; e.d = d0; end
      endcase
      wrQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every cycle either the queued write is due and must appear, or wec must be low
  // with addrc/dc holding their previous value.
  initial begin
    wrT e;
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        holdAddr = '0;
        holdData = '0;
        armed = 1'b1;
      end
      confExp = confNext;
      @(negedge clk);
      if (armed) begin
        if (wrQ.size() > 0 && wrQ[0].due == cyc) begin
          e = wrQ.pop_front();
          checkOutput("wec_hi", {31'd0, wec}, 32'd1);
          checkOutput("addrc", {27'd0, addrc}, {27'd0, e.a});
          checkOutput("dc", dc, e.d);
          holdAddr = e.a;
          holdData = e.d;
        end else begin
          checkOutput("wec_lo", {31'd0, wec}, 32'd0);
          checkOutput("addrc_hold", {27'd0, addrc}, {27'd0, holdAddr});
          checkOutput("dc_hold", dc, holdData);
        end
        checkOutput("conflict", {31'd0, conflict}, {31'd0, confExp});
        if (wec === 1'b1) rfModel[addrc] = dc;
      end
    end
  end

  initial begin
    // Reset two cycles with all sources requesting
    applyStimulus(1'b1, 1'b0, 3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    applyStimulus(1'b1, 1'b0, 3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    idle(1);

    // Single request from the load source
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    idle(2);

    // ptr=2: source 2 alone brings ptr back to 0
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b100, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h33330000);

    // Round robin with all three requesting continuously
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 32'hC0);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b010, 5'd13, 5'd14, 5'd15, 32'hA1, 32'hB1, 32'hC1);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b100, 5'd16, 5'd17, 5'd18, 32'hA2, 32'hB2, 32'hC2);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001, 5'd19, 5'd20, 5'd21, 32'hA3, 32'hB3, 32'hC3);
    idle(1);

    // ptr=1 -> 100 returns ptr to 0, then fairness after skipping source 0
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b100, 5'd0, 5'd0, 5'd22, 32'd0, 32'd0, 32'h22);
    applyStimulus(1'b0, 1'b0, 3'b110, 3'b010, 5'd0, 5'd23, 5'd24, 32'd0, 32'h23, 32'h24);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b100, 5'd25, 5'd26, 5'd27, 32'h25, 32'h26, 32'h27);
    applyStimulus(1'b0, 1'b0, 3'b111, 3'b001, 5'd28, 5'd29, 5'd30, 32'h28, 32'h29, 32'h30);
    idle(1);

    // Halt: grant, three halted cycles with req held, then release
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b001, 5'd4, 5'd0, 5'd0, 32'h4444, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 5'd6, 5'd0, 5'd0, 32'h6666, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 5'd6, 5'd0, 5'd0, 32'h6666, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b000, 5'd6, 5'd0, 5'd0, 32'h6666, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b001, 5'd6, 5'd0, 5'd0, 32'h6666, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    idle(1);

    // Same destination from two sources, ptr brought to 0 first
    applyStimulus(1'b0, 1'b0, 3'b100, 3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h99);
    applyStimulus(1'b0, 1'b0, 3'b011, 3'b001, 5'd7, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b010, 5'd7, 5'd7, 5'd0, 32'h1, 32'h2, 32'd0);
    idle(1);

    // Reset while requesting loses the grant; register 0 is written unfiltered
    applyStimulus(1'b1, 1'b0, 3'b001, 3'b000, 5'd8, 5'd0, 5'd0, 32'h8888, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b001, 5'd0, 5'd0, 5'd0, 32'hAAAA5555, 32'd0, 32'd0);
    idle(3);

    checkOutput("queue_empty", wrQ.size(), 32'd0);
    checkOutput("rf7", rfModel[7], 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
